// File: rtl/botones_debounce.sv
`default_nettype none
// ============================================================================
//  Module   : botones_debounce
//  Purpose  : Synchronises and debounces five push-buttons (U, D, L, R, C)
//             and turns each accepted press into an update of the ALU
//             operation select (ALUControl) and shift amount (Cantidad).
//             A one-cycle op_changed pulse flags every real value change.
//  Revision : 1.0 - initial release
// ============================================================================
module botones_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btnU,
  input  logic       btnD,
  input  logic       btnL,
  input  logic       btnR,
  input  logic       btnC,
  output logic [2:0] ALUControl,
  output logic [1:0] Cantidad,
  output logic       op_changed,
  output logic [4:0] btn_level
);

  // The per-button counter holds "samples seen minus one", so a counter of
  // clog2(DEBOUNCE_CYCLES) bits is enough to reach the terminal count.
  localparam int unsigned c_CW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [c_CW-1:0] c_LAST = c_CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [c_CW-1:0] c_ONE  = c_CW'(1);

  // Bit index of each button inside the packed vectors {C,R,L,D,U}
  localparam int unsigned c_IDX_U = 0;
  localparam int unsigned c_IDX_D = 1;
  localparam int unsigned c_IDX_L = 2;
  localparam int unsigned c_IDX_R = 3;
  localparam int unsigned c_IDX_C = 4;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_ARMING    = 2'd1,
    ST_PRESSED   = 2'd2,
    ST_RELEASING = 2'd3
  } state_t;

  // --------------------------------------------------------------------------
  // Reset: asserted asynchronously, released synchronously so that every
  // button FSM and the output registers leave reset on the same clk edge.
  // --------------------------------------------------------------------------
  logic [1:0] r_rst_sync;
  logic       w_rst_n;

  // Two-stage reset release synchroniser
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rst_sync <= 2'b00;
    end else begin
      r_rst_sync <= {r_rst_sync[0], 1'b1};
    end
  end

  assign w_rst_n = r_rst_sync[1];

  // --------------------------------------------------------------------------
  // Input synchronisers. These run from the raw reset so they start sampling
  // on the first edge after rst_n rises; by the time the synchronised level
  // reaches the FSMs, the FSMs have just been released from reset.
  // --------------------------------------------------------------------------
  logic [4:0] w_raw;
  logic [4:0] r_sync1;
  logic [4:0] r_sync2;

  assign w_raw = {btnC, btnR, btnL, btnD, btnU};

  // Two-flop synchroniser per raw button level
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= 5'b00000;
      r_sync2 <= 5'b00000;
    end else begin
      r_sync1 <= w_raw;
      r_sync2 <= r_sync1;
    end
  end

  // --------------------------------------------------------------------------
  // One debounce FSM per button
  // --------------------------------------------------------------------------
  logic [4:0] w_press;

  generate
    for (genvar gi = 0; gi < 5; gi++) begin : g_btn
      state_t          r_state;
      state_t          w_state_nxt;
      logic [c_CW-1:0] r_cnt;
      logic [c_CW-1:0] w_cnt_nxt;
      logic            w_s;
      logic            w_evt;

      assign w_s = r_sync2[gi];

      // State and counter registers
      always_ff @(posedge clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
          r_state <= ST_IDLE;
          r_cnt   <= '0;
        end else begin
          r_state <= w_state_nxt;
          r_cnt   <= w_cnt_nxt;
        end
      end

      // Next-state, counter and press-event decode
      always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_evt       = 1'b0;
        case (r_state)
          ST_IDLE: begin
            w_cnt_nxt = '0;
            if (w_s) begin
              // first high sample already counts as one
              w_state_nxt = ST_ARMING;
            end
          end
          ST_ARMING: begin
            if (!w_s) begin
              w_state_nxt = ST_IDLE;
              w_cnt_nxt   = '0;
            end else if (r_cnt == c_LAST) begin
              w_state_nxt = ST_PRESSED;
              w_cnt_nxt   = '0;
              w_evt       = 1'b1;
            end else begin
              w_cnt_nxt = r_cnt + c_ONE;
            end
          end
          ST_PRESSED: begin
            w_cnt_nxt = '0;
            if (!w_s) begin
              // first low sample already counts as one
              w_state_nxt = ST_RELEASING;
            end
          end
          ST_RELEASING: begin
            if (w_s) begin
              // bounce during release: still held, no new event
              w_state_nxt = ST_PRESSED;
              w_cnt_nxt   = '0;
            end else if (r_cnt == c_LAST) begin
              w_state_nxt = ST_IDLE;
              w_cnt_nxt   = '0;
            end else begin
              w_cnt_nxt = r_cnt + c_ONE;
            end
          end
          default: begin
            w_state_nxt = ST_IDLE;
            w_cnt_nxt   = '0;
          end
        endcase
      end

      assign w_press[gi]   = w_evt;
      assign btn_level[gi] = (r_state == ST_PRESSED) || (r_state == ST_RELEASING);
    end
  endgenerate

  // --------------------------------------------------------------------------
  // Operation / amount registers. Press events are decoded combinationally so
  // the registers take their new value on the same edge the FSM enters
  // PRESSED.
  // --------------------------------------------------------------------------
  logic [2:0] r_alu;
  logic [1:0] r_cant;
  logic       r_op_changed;
  logic [2:0] w_alu_nxt;
  logic [1:0] w_cant_nxt;

  // Combine the press events of this cycle into new register values
  always_comb begin
    w_alu_nxt  = r_alu;
    w_cant_nxt = r_cant;
    if (w_press[c_IDX_C]) begin
      // clear wins over anything else pressed in the same cycle
      w_alu_nxt  = 3'b000;
      w_cant_nxt = 2'b00;
    end else begin
      case ({w_press[c_IDX_U], w_press[c_IDX_D]})
        2'b10:   w_alu_nxt = r_alu + 3'd1;
        2'b01:   w_alu_nxt = r_alu - 3'd1;
        default: w_alu_nxt = r_alu;
      endcase
      case ({w_press[c_IDX_R], w_press[c_IDX_L]})
        2'b10:   w_cant_nxt = r_cant + 2'd1;
        2'b01:   w_cant_nxt = r_cant - 2'd1;
        default: w_cant_nxt = r_cant;
      endcase
    end
  end

  // Output registers; op_changed flags only a real change of value
  always_ff @(posedge clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_alu        <= 3'b000;
      r_cant       <= 2'b00;
      r_op_changed <= 1'b0;
    end else begin
      r_alu        <= w_alu_nxt;
      r_cant       <= w_cant_nxt;
      r_op_changed <= (w_alu_nxt != r_alu) || (w_cant_nxt != r_cant);
    end
  end

  assign ALUControl = r_alu;
  assign Cantidad   = r_cant;
  assign op_changed = r_op_changed;

endmodule
`default_nettype wire

// File: tb/tb_botones_debounce.sv
`default_nettype none
// ============================================================================
//  Module   : tb_botones_debounce
//  Purpose  : Directed self-checking bench for botones_debounce with
//             DEBOUNCE_CYCLES = 4 (press accepted 6 edges after first sample).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_botones_debounce;

  logic       clk;
  logic       rst_n;
  logic [4:0] r_btn;   // {C,R,L,D,U}
  logic [2:0] ALUControl;
  logic [1:0] Cantidad;
  logic       op_changed;
  logic [4:0] btn_level;

  int n_tests;
  int n_fail;

  botones_debounce #(.DEBOUNCE_CYCLES(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .btnU       (r_btn[0]),
    .btnD       (r_btn[1]),
    .btnL       (r_btn[2]),
    .btnR       (r_btn[3]),
    .btnC       (r_btn[4]),
    .ALUControl (ALUControl),
    .Cantidad   (Cantidad),
    .op_changed (op_changed),
    .btn_level  (btn_level)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // advance one rising edge and sample 1 ns later
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    r_btn = 5'b00000;
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    repeat (4) tick();
  endtask

  // press a button mask long enough for one event, then release fully
  task automatic press_release(input logic [4:0] m);
    r_btn = m;
    repeat (8) tick();
    r_btn = 5'b00000;
    repeat (12) tick();
  endtask

  initial begin
    logic [7:0] pat;
    n_tests = 0;
    n_fail  = 0;
    r_btn   = 5'b00000;
    rst_n   = 1'b0;

    // ---------------- reset state ----------------
    repeat (3) tick();
    check("rst_alu",   ALUControl, 0);
    check("rst_cant",  Cantidad,   0);
    check("rst_opc",   op_changed, 0);
    check("rst_level", btn_level,  0);
    rst_n = 1'b1;
    repeat (4) tick();

    // ---------------- clean press of U ----------------
    r_btn = 5'b00001;
    for (int j = 0; j <= 6; j++) begin
      tick();
      check("clean_alu", ALUControl, (j >= 6) ? 1 : 0);
      check("clean_opc", op_changed, (j == 6) ? 1 : 0);
    end
    check("clean_level", btn_level, 5'b00001);
    for (int j = 7; j < 100; j++) begin
      tick();
      check("hold_alu", ALUControl, 1);
      check("hold_opc", op_changed, 0);
    end
    r_btn = 5'b00000;
    repeat (12) tick();
    check("release_level", btn_level, 0);
    check("release_alu",   ALUControl, 1);

    // ---------------- bounce on U ----------------
    pat = 8'b0111_0111;
    for (int j = 0; j < 22; j++) begin
      r_btn[0] = (j < 8) ? pat[j] : 1'b1;
      tick();
      check("bounce_alu", ALUControl, (j >= 14) ? 2 : 1);
      check("bounce_opc", op_changed, (j == 14) ? 1 : 0);
    end
    r_btn = 5'b00000;
    repeat (12) tick();

    // ---------------- wrap-around ----------------
    do_reset();
    press_release(5'b00010);          // D
    check("wrap_alu_d", ALUControl, 7);
    press_release(5'b00100);          // L
    check("wrap_cant_l", Cantidad, 3);
    press_release(5'b01000);          // R
    press_release(5'b01000);          // R
    check("wrap_cant_rr", Cantidad, 1);
    check("wrap_alu_keep", ALUControl, 7);

    // ---------------- U and L together ----------------
    do_reset();
    r_btn = 5'b00101;
    for (int j = 0; j < 8; j++) begin
      tick();
      check("ul_alu",  ALUControl, (j >= 6) ? 1 : 0);
      check("ul_cant", Cantidad,   (j >= 6) ? 3 : 0);
      check("ul_opc",  op_changed, (j == 6) ? 1 : 0);
    end
    r_btn = 5'b00000;
    repeat (12) tick();

    // ---------------- U and D together ----------------
    r_btn = 5'b00011;
    for (int j = 0; j < 8; j++) begin
      tick();
      check("ud_alu", ALUControl, 1);
      check("ud_opc", op_changed, 0);
    end
    check("ud_level", btn_level, 5'b00011);
    r_btn = 5'b00000;
    repeat (12) tick();

    // ---------------- C with U from 011/10 ----------------
    press_release(5'b00001);          // U -> 010
    press_release(5'b00001);          // U -> 011
    press_release(5'b00100);          // L -> 10
    check("pre_c_alu",  ALUControl, 3);
    check("pre_c_cant", Cantidad,   2);
    r_btn = 5'b10001;
    for (int j = 0; j < 8; j++) begin
      tick();
      check("cu_alu",  ALUControl, (j >= 6) ? 0 : 3);
      check("cu_cant", Cantidad,   (j >= 6) ? 0 : 2);
      check("cu_opc",  op_changed, (j == 6) ? 1 : 0);
    end
    r_btn = 5'b00000;
    repeat (12) tick();

    // C again with values already cleared: no pulse
    r_btn = 5'b10000;
    for (int j = 0; j < 8; j++) begin
      tick();
      check("c_zero_opc", op_changed, 0);
    end
    check("c_level", btn_level, 5'b10000);
    r_btn = 5'b00000;
    repeat (12) tick();

    // ---------------- reset mid-operation ----------------
    press_release(5'b00001);          // U -> 001
    check("mid_pre_alu", ALUControl, 1);
    r_btn = 5'b01000;
    repeat (3) tick();
    rst_n = 1'b0;
    #1;
    check("mid_rst_alu",   ALUControl, 0);
    check("mid_rst_cant",  Cantidad,   0);
    check("mid_rst_opc",   op_changed, 0);
    check("mid_rst_level", btn_level,  0);
    tick();
    tick();
    rst_n = 1'b1;
    for (int j = 0; j < 10; j++) begin
      tick();
      check("mid_cant", Cantidad,   (j >= 6) ? 1 : 0);
      check("mid_opc",  op_changed, (j == 6) ? 1 : 0);
      check("mid_alu",  ALUControl, 0);
    end
    r_btn = 5'b00000;
    repeat (4) tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
